ifu: RTL and testbench

Instruction fetch unit for the RV32I core: owns the architectural PC and fetches instruction words from instruction memory over a request/grant/response handshake. It presents `inst`, `pc` and `pc4` to the decode stage with a valid/ready handshake. On each accepted instruction it computes the next PC from the branch/jump controls and the execute results. It sits directly upstream of decode; its `inst`/`pc`/`pc4` outputs feed decode's `inst`/`pc`/`pc4` inputs.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_npc.sv | 48 ++++
 rtl/ifu.sv | 141 ++++++++++++++
 tb/tb_ifu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared constants for the instruction fetch unit and its next-PC helper.
//   NPC_*     : next-PC select encodings driven by decode/execute on npc_op
//   INST_NOP  : canonical RV32I NOP (addi x0, x0, 0), the reset value of inst
//   XLEN      : architectural register / address width
// -----------------------------------------------------------------------------
package ifu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JAL  = 2'd2;
    localparam logic [1:0] NPC_JALR = 2'd3;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    // RV32I without the C extension requires 4-byte aligned fetch targets.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// -----------------------------------------------------------------------------
// ifu_npc
// Purely combinational next-PC computation for the fetch unit.
// Ports:
//   i_pc       in  32 : address of the instruction being retired from fetch
//   i_npc_op   in  2  : next-PC select (NPC_PC4/NPC_BR/NPC_JAL/NPC_JALR)
//   i_br_taken in  1  : branch condition, only meaningful with NPC_BR
//   i_ext      in  32 : sign-extended branch/JAL offset
//   i_aluc     in  32 : ALU result, the JALR target before bit-0 clearing
//   o_npc      out 32 : computed next PC (modulo 2^32)
//   o_misalign out 1  : o_npc is not word aligned
// -----------------------------------------------------------------------------
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_npc_op,
    input  logic        i_br_taken,
    input  logic [31:0] i_ext,
    input  logic [31:0] i_aluc,
    output logic [31:0] o_npc,
    output logic        o_misalign
);

    logic [31:0] w_pc4;
    logic [31:0] w_pc_rel;
    logic [31:0] w_jalr;

    // All sums wrap naturally at 32 bits; no overflow detection is wanted.
    assign w_pc4    = i_pc + 32'd4;
    assign w_pc_rel = i_pc + i_ext;
    // JALR clears bit 0 only; a set bit 1 survives and is caught as misaligned.
    assign w_jalr   = i_aluc & ~32'h1;

    always_comb begin
        o_npc = w_pc4;
        case (i_npc_op)
            NPC_PC4:  o_npc = w_pc4;
            NPC_BR:   o_npc = i_br_taken ? w_pc_rel : w_pc4;
            NPC_JAL:  o_npc = w_pc_rel;
            NPC_JALR: o_npc = w_jalr;
            default:  o_npc = w_pc4;
        endcase
    end

    assign o_misalign = is_misaligned(o_npc);

endmodule

// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu
// Instruction fetch unit for the RV32I core. Owns the architectural PC, fetches
// one instruction word at a time over a req/gnt/rvalid memory handshake and
// hands it to decode with a valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   npc_op, br_taken,
//   ext, aluc     in    : next-PC controls, sampled only when inst is accepted
//   inst_ready    in    : downstream accepts the presented instruction
//   inst_valid    out   : inst/pc/pc4 are valid
//   inst, pc      out   : fetched word and its address (registered)
//   pc4           out   : pc + 4 (combinational from the pc register)
//   fault         out   : sticky misaligned-target fault
//   imem_req      out   : fetch request (registered)
//   imem_addr     out   : fetch address, always equal to pc
//   imem_gnt      in    : request accepted by memory
//   imem_rvalid   in    : response word valid
//   imem_rdata    in    : response instruction word
// -----------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] ext,
    input  logic [31:0] aluc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fault,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_imem_req;
    logic        r_fault;

    logic [31:0] w_npc;
    logic        w_misalign;

    ifu_npc u_npc (
        .i_pc       (r_pc),
        .i_npc_op   (npc_op),
        .i_br_taken (br_taken),
        .i_ext      (ext),
        .i_aluc     (aluc),
        .o_npc      (w_npc),
        .o_misalign (w_misalign)
    );

    // Outputs are registered alongside the state so that each output's value
    // is decided in the same branch that decides the next state. gnt outside
    // REQ and rvalid outside WAIT fall through untouched, which is what drops
    // stale responses still in flight from before a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= INST_NOP;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    // pc is not touched here, so imem_addr stays stable
                    // for as long as the grant is withheld.
                    if (imem_gnt) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_inst       <= imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        if (w_misalign) begin
                            // pc keeps the faulting instruction's address.
                            r_fault <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_pc       <= w_npc;
                            r_imem_req <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    r_inst_valid <= 1'b0;
                    r_imem_req   <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_inst_valid <= 1'b0;
                    r_imem_req   <= 1'b0;
                end
            endcase
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign pc4        = r_pc + 32'd4;
    assign fault      = r_fault;
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    localparam logic [1:0] OP_PC4  = 2'd0;
    localparam logic [1:0] OP_BR   = 2'd1;
    localparam logic [1:0] OP_JAL  = 2'd2;
    localparam logic [1:0] OP_JALR = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] ext;
    logic [31:0] aluc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    int total = 0;
    int bad   = 0;

    ifu #(.RESET_PC(32'h0000_1000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_op      (npc_op),
        .br_taken    (br_taken),
        .ext         (ext),
        .aluc        (aluc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .pc          (pc),
        .pc4         (pc4),
        .fault       (fault),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step off it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in REQ: grant now, answer the next cycle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        chk1 ("req_asserted", imem_req, 1'b1);
        chk32("req_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk1 ("req_dropped", imem_req, 1'b0);
        chk1 ("no_valid_in_wait", inst_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk1 ("valid", inst_valid, 1'b1);
        chk32("inst", inst, word);
        chk32("pc", pc, addr);
        chk32("pc4", pc4, addr + 32'd4);
        $display("fetch addr=%h inst=%h", pc, inst);
    endtask

    // Called with the DUT in VALID: accept with the given next-PC controls.
    task automatic accept(input logic [1:0] op, input logic bt,
                          input logic [31:0] e, input logic [31:0] a);
        npc_op     = op;
        br_taken   = bt;
        ext        = e;
        aluc       = a;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        npc_op     = OP_PC4;
        br_taken   = 1'b0;
        ext        = 32'h0;
        aluc       = 32'h0;
        chk1("valid_after_accept", inst_valid, 1'b0);
        $display("accept op=%0d next_pc=%h fault=%b", op, pc, fault);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        npc_op      = OP_PC4;
        br_taken    = 1'b0;
        ext         = 32'h0;
        aluc        = 32'h0;
        inst_ready  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Reset values
        #12;
        chk1 ("rst_valid", inst_valid, 1'b0);
        chk1 ("rst_req", imem_req, 1'b0);
        chk1 ("rst_fault", fault, 1'b0);
        chk32("rst_inst", inst, 32'h0000_0013);
        chk32("rst_pc", pc, 32'h0000_1000);
        chk32("rst_pc4", pc4, 32'h0000_1004);
        $display("reset pc=%h inst=%h", pc, inst);
        @(negedge clk);
        rst_n = 1'b1;

        // First fetch: request in cycle 1, valid in cycle 3
        tick();
        fetch(32'h0000_1000, 32'h0000_0093);

        // Sequential stream
        accept(OP_PC4, 1'b0, 32'h0, 32'h0);
        fetch(32'h0000_1004, 32'h0010_0113);
        accept(OP_PC4, 1'b0, 32'h0, 32'h0);
        fetch(32'h0000_1008, 32'h0020_0193);

        // Backpressure: five cycles without ready
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1 ("bp_valid", inst_valid, 1'b1);
            chk32("bp_inst", inst, 32'h0020_0193);
            chk32("bp_pc", pc, 32'h0000_1008);
            chk1 ("bp_no_req", imem_req, 1'b0);
        end
        $display("backpressure held pc=%h", pc);

        // Grant stalled four cycles
        accept(OP_PC4, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1 ("stall_req", imem_req, 1'b1);
            chk32("stall_addr", imem_addr, 32'h0000_100C);
        end
        $display("grant stall addr=%h", imem_addr);
        fetch(32'h0000_100C, 32'h0030_0213);

        // Return to 0x1000 through JALR
        accept(OP_JALR, 1'b0, 32'h0, 32'h0000_1000);
        fetch(32'h0000_1000, 32'h0000_0063);
        // Taken backward branch
        accept(OP_BR, 1'b1, 32'hFFFF_FFF8, 32'h0);
        fetch(32'h0000_0FF8, 32'h0000_006F);
        // JAL forward by 8
        accept(OP_JAL, 1'b0, 32'h0000_0008, 32'h0);
        fetch(32'h0000_1000, 32'h0000_0063);
        // Not-taken branch ignores ext
        accept(OP_BR, 1'b0, 32'h0000_0100, 32'h0);
        fetch(32'h0000_1004, 32'h0000_0067);
        // JALR clears bit 0 of an odd target
        accept(OP_JALR, 1'b0, 32'h0, 32'hFFFF_FFFD);
        fetch(32'hFFFF_FFFC, 32'h0000_0013);
        // Wrap-around
        accept(OP_PC4, 1'b0, 32'h0, 32'h0);
        fetch(32'h0000_0000, 32'h0000_0013);
        accept(OP_JALR, 1'b0, 32'h0, 32'h0000_1001);
        fetch(32'h0000_1000, 32'h0000_0067);

        // Misaligned JALR target: fault and halt
        accept(OP_JALR, 1'b0, 32'h0, 32'h0000_2003);
        chk1 ("fault_set", fault, 1'b1);
        chk32("fault_pc", pc, 32'h0000_1000);
        chk1 ("fault_no_req", imem_req, 1'b0);
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        inst_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1 ("halt_req", imem_req, 1'b0);
            chk1 ("halt_valid", inst_valid, 1'b0);
            chk1 ("halt_fault", fault, 1'b1);
            chk32("halt_pc", pc, 32'h0000_1000);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        $display("halt fault=%b pc=%h", fault, pc);

        // Asynchronous reset clears the fault without waiting for an edge
        rst_n = 1'b0;
        #1;
        chk1 ("async_rst_fault", fault, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk1 ("restart_req", imem_req, 1'b1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk1 ("in_wait", imem_req, 1'b0);

        // Reset while WAIT, then a stale response right after release
        rst_n = 1'b0;
        #1;
        chk1 ("wait_rst_req", imem_req, 1'b0);
        chk32("wait_rst_inst", inst, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        chk1 ("post_rst_req", imem_req, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk1 ("stale_valid", inst_valid, 1'b0);
        chk32("stale_inst", inst, 32'h0000_0013);
        $display("stale response dropped inst=%h", inst);
        fetch(32'h0000_1000, 32'h0040_0293);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
